pipe_control_unit: RTL and testbench

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_decode.sv | 73 +++++++
 rtl/pipe_control_unit.sv | 161 ++++++++++++++++
 tb/tb_pipe_control_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the MIPS-style pipeline controller: opcodes,
// ALU operation codes, FSM state, per-cycle action and the ID/EX control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_RTYPE = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h04;
  localparam logic [5:0] OP_BEQ   = 6'h05;
  localparam logic [5:0] OP_JAL   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_FP    = 6'h11;
  localparam logic [5:0] OP_LW    = 6'h12;
  localparam logic [5:0] OP_LBU   = 6'h22;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [3:0] ALU_NONE  = 4'h0;
  localparam logic [3:0] ALU_FUNCT = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_ADD   = 4'h4;
  localparam logic [3:0] ALU_AND   = 4'h5;
  localparam logic [3:0] ALU_SUB   = 4'h7;
  localparam logic [3:0] ALU_LUI   = 4'hB;

  // Wide enough for FP_LAT up to 15.
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_FP_BUSY
  } fsm_state_e;

  typedef enum logic [2:0] {
    ACT_FLUSH,
    ACT_HOLD,
    ACT_FP_WAIT,
    ACT_BUBBLE,
    ACT_ISSUE
  } action_e;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jump;
    logic       jmp_and_link;
    logic       mem_read;
    logic       mem_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       alu_src;
    logic       float_op;
    logic       is_signed;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder; produces the full control bundle and a
// legality flag so any datapath (pipelined or single-cycle) can reuse it.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       legal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
    ctrl_o  = CTRL_BUBBLE;
    legal_o = 1'b1;
    case (opcode_i)
      OP_NOP: ;
      OP_LW, OP_LBU: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.is_signed  = 1'b1;
        ctrl_o.alu_op     = ALU_ADD;
      end
      OP_LUI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_LUI;
      end
      OP_SB, OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.is_signed = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
      end
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = (opcode_i == OP_ADDI) ? ALU_ADD :
                           (opcode_i == OP_ANDI) ? ALU_AND : ALU_OR;
      end
      OP_BEQ: begin
        ctrl_o.branch_eq = 1'b1;
        ctrl_o.alu_op    = ALU_SUB;
      end
      OP_BNE: begin
        ctrl_o.branch_ne = 1'b1;
        ctrl_o.alu_op    = ALU_SUB;
      end
      OP_JAL: begin
        ctrl_o.jmp_and_link = 1'b1;
        ctrl_o.alu_op       = ALU_ADD;
      end
      OP_J: begin
        ctrl_o.jump   = 1'b1;
        ctrl_o.alu_op = ALU_ADD;
      end
      OP_FP: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.float_op  = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// ID/EX control register with load-use interlock and a multi-cycle FP stall
// FSM; one action per cycle chosen by flush > stall_in > FP_BUSY > hazard > issue.
module pipe_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int FP_LAT  = 4,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [5:0]         opcode,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic               stall_in,
  input  logic               flush,
  output logic               ex_valid,
  output logic               ex_RegDst,
  output logic               ex_RegWrite,
  output logic               ex_MemtoReg,
  output logic               ex_Jump,
  output logic               ex_JmpandLink,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_BranchEqual,
  output logic               ex_BranchnotEqual,
  output logic               ex_ALUSrc,
  output logic               ex_floatop,
  output logic               ex_Issigned,
  output logic [ALUOP_W-1:0] ex_ALUop,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   ex_dest,
  output logic               if_stall,
  output logic               fp_busy,
  output logic               ex_illegal
);

  ctrl_t            id_ctrl;
  logic             id_legal;
  ctrl_t            ex_ctrl_q, ex_ctrl_d;
  logic             ex_valid_q, ex_valid_d;
  logic             ex_illegal_q, ex_illegal_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d;
  logic [REG_W-1:0] ex_dest_q, ex_dest_d;
  fsm_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  action_e          action;
  logic             load_use;
  logic             issue_fp;

  ctrl_decode u_decode (
    .opcode_i (opcode),
    .ctrl_o   (id_ctrl),
    .legal_o  (id_legal)
  );

  assign load_use = ex_valid_q & ex_ctrl_q.mem_read & id_valid & (ex_rt_q != '0)
                  & ((ex_rt_q == rs) | (ex_rt_q == rt));
  assign issue_fp = id_valid & id_legal & id_ctrl.float_op;
  assign if_stall = ~flush & (stall_in | (state_q == ST_FP_BUSY) | load_use);
  assign fp_busy  = (state_q == ST_FP_BUSY);

  always_comb begin
    if (flush)                        action = ACT_FLUSH;
    else if (stall_in)                action = ACT_HOLD;
    else if (state_q == ST_FP_BUSY)   action = ACT_FP_WAIT;
    else if (load_use)                action = ACT_BUBBLE;
    else                              action = ACT_ISSUE;
  end

  // Default is a bubble; only HOLD and ISSUE load anything else.
  always_comb begin
    ex_ctrl_d    = CTRL_BUBBLE;
    ex_valid_d   = 1'b0;
    ex_illegal_d = 1'b0;
    ex_rt_d      = '0;
    ex_dest_d    = '0;
    case (action)
      ACT_HOLD: begin
        ex_ctrl_d    = ex_ctrl_q;
        ex_valid_d   = ex_valid_q;
        ex_illegal_d = ex_illegal_q;
        ex_rt_d      = ex_rt_q;
        ex_dest_d    = ex_dest_q;
      end
      ACT_ISSUE: begin
        ex_illegal_d = id_valid & ~id_legal;
        if (id_valid && id_legal) begin
          ex_ctrl_d  = id_ctrl;
          ex_valid_d = 1'b1;
          ex_rt_d    = rt;
          ex_dest_d  = id_ctrl.reg_dst ? rd : rt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q    <= CTRL_BUBBLE;
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
      ex_rt_q      <= '0;
      ex_dest_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values, independent of statement order.
      ex_ctrl_q    <= ex_ctrl_d;
      ex_valid_q   <= ex_valid_d;
      ex_illegal_q <= ex_illegal_d;
      ex_rt_q      <= ex_rt_d;
      ex_dest_q    <= ex_dest_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (action)
        ACT_FLUSH: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
        ACT_FP_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_IDLE;
        end
        ACT_ISSUE: begin
          if (issue_fp && FP_LAT > 1) begin
            state_q <= ST_FP_BUSY;
            cnt_q   <= CNT_W'(FP_LAT - 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ex_valid          = ex_valid_q;
  assign ex_illegal        = ex_illegal_q;
  assign ex_rt             = ex_rt_q;
  assign ex_dest           = ex_dest_q;
  assign ex_RegDst         = ex_ctrl_q.reg_dst;
  assign ex_RegWrite       = ex_ctrl_q.reg_write;
  assign ex_MemtoReg       = ex_ctrl_q.mem_to_reg;
  assign ex_Jump           = ex_ctrl_q.jump;
  assign ex_JmpandLink     = ex_ctrl_q.jmp_and_link;
  assign ex_MemRead        = ex_ctrl_q.mem_read;
  assign ex_MemWrite       = ex_ctrl_q.mem_write;
  assign ex_BranchEqual    = ex_ctrl_q.branch_eq;
  assign ex_BranchnotEqual = ex_ctrl_q.branch_ne;
  assign ex_ALUSrc         = ex_ctrl_q.alu_src;
  assign ex_floatop        = ex_ctrl_q.float_op;
  assign ex_Issigned       = ex_ctrl_q.is_signed;
  assign ex_ALUop          = ALUOP_W'(ex_ctrl_q.alu_op);

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_pipe_control_unit;

  localparam int FP_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, stall_in, flush;
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic       ex_valid, ex_RegDst, ex_RegWrite, ex_MemtoReg, ex_Jump, ex_JmpandLink;
  logic       ex_MemRead, ex_MemWrite, ex_BranchEqual, ex_BranchnotEqual, ex_ALUSrc;
  logic       ex_floatop, ex_Issigned, if_stall, fp_busy, ex_illegal;
  logic [3:0] ex_ALUop;
  logic [4:0] ex_rt, ex_dest;
  logic [15:0] obs_ctrl;

  pipe_control_unit #(.FP_LAT(FP_LAT), .REG_W(5), .ALUOP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .stall_in(stall_in), .flush(flush),
    .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_RegWrite(ex_RegWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_Jump(ex_Jump), .ex_JmpandLink(ex_JmpandLink),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_BranchEqual(ex_BranchEqual), .ex_BranchnotEqual(ex_BranchnotEqual),
    .ex_ALUSrc(ex_ALUSrc), .ex_floatop(ex_floatop), .ex_Issigned(ex_Issigned),
    .ex_ALUop(ex_ALUop), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .if_stall(if_stall), .fp_busy(fp_busy), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  assign obs_ctrl = {ex_RegDst, ex_RegWrite, ex_MemtoReg, ex_Jump, ex_JmpandLink,
                     ex_MemRead, ex_MemWrite, ex_BranchEqual, ex_BranchnotEqual,
                     ex_ALUSrc, ex_floatop, ex_Issigned, ex_ALUop};

  int    n_asserts = 0;
  int    n_fail    = 0;
  string phase     = "init";

  // Reference model state: what EX should hold and how many FP wait cycles remain.
  logic        m_valid, m_illegal, m_last_stall;
  logic [15:0] m_ctrl;
  logic [4:0]  m_rt, m_dest;
  int          m_fp_left;

  logic [5:0] op_pool [18] = '{6'h00, 6'h12, 6'h22, 6'h0f, 6'h28, 6'h2b, 6'h03, 6'h09,
                               6'h0c, 6'h0e, 6'h05, 6'h04, 6'h07, 6'h02, 6'h11, 6'h3f,
                               6'h01, 6'h20};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flag string order: RegDst RegWrite MemtoReg Jump JmpandLink MemRead MemWrite
  // BranchEqual BranchnotEqual ALUSrc floatop Issigned, then the ALUop nibble.
  function automatic logic [15:0] row(input string f, input logic [3:0] alu);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r[15-i] = (f[i] == 8'h31);
    r[3:0] = alu;
    return r;
  endfunction

  function automatic logic ref_decode(input logic [5:0] op, output logic [15:0] f);
    ref_decode = 1'b1;
    case (op)
      6'h00:        f = row("000000000000", 4'h0);
      6'h12, 6'h22: f = row("011001000101", 4'h4);
      6'h0f:        f = row("010000000100", 4'hB);
      6'h28, 6'h2b: f = row("000000100101", 4'h4);
      6'h03:        f = row("110000000000", 4'h2);
      6'h09:        f = row("010000000100", 4'h4);
      6'h0c:        f = row("010000000100", 4'h5);
      6'h0e:        f = row("010000000100", 4'h3);
      6'h05:        f = row("000000010000", 4'h7);
      6'h04:        f = row("000000001000", 4'h7);
      6'h07:        f = row("000010000000", 4'h4);
      6'h02:        f = row("000100000000", 4'h4);
      6'h11:        f = row("110000000010", 4'h2);
      default: begin
        f = '0;
        ref_decode = 1'b0;
      end
    endcase
  endfunction

  function automatic logic m_hazard();
    return m_valid && m_ctrl[10] && id_valid && (m_rt != 5'd0) && (m_rt == rs || m_rt == rt);
  endfunction

  task automatic m_reset();
    m_valid = 1'b0; m_illegal = 1'b0; m_ctrl = '0; m_rt = '0; m_dest = '0;
    m_fp_left = 0; m_last_stall = 1'b0;
  endtask

  task automatic m_bubble(input logic illegal);
    m_valid = 1'b0; m_illegal = illegal; m_ctrl = '0; m_rt = '0; m_dest = '0;
  endtask

  task automatic model_edge();
    logic        legal;
    logic [15:0] f;
    if (flush) begin
      m_bubble(1'b0);
      m_fp_left = 0;
    end else if (stall_in) begin
      // everything frozen
    end else if (m_fp_left > 0) begin
      m_bubble(1'b0);
      m_fp_left--;
    end else if (m_hazard()) begin
      m_bubble(1'b0);
    end else begin
      legal = ref_decode(opcode, f);
      if (id_valid && legal) begin
        m_valid = 1'b1; m_illegal = 1'b0; m_ctrl = f; m_rt = rt;
        m_dest = f[15] ? rd : rt;
        if (f[5]) m_fp_left = FP_LAT - 1;
      end else begin
        m_bubble(id_valid);
      end
    end
  endtask

  task automatic check_regs();
    check({phase, ".ex_valid"},   32'(ex_valid),   32'(m_valid));
    check({phase, ".ex_illegal"}, 32'(ex_illegal), 32'(m_illegal));
    check({phase, ".ctrl"},       32'(obs_ctrl),   32'(m_ctrl));
    check({phase, ".ex_rt"},      32'(ex_rt),      32'(m_rt));
    check({phase, ".ex_dest"},    32'(ex_dest),    32'(m_dest));
    check({phase, ".fp_busy"},    32'(fp_busy),    32'(m_fp_left > 0));
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    logic e_stall;
    #1;
    e_stall = !flush && (stall_in || (m_fp_left > 0) || m_hazard());
    check({phase, ".if_stall"}, 32'(if_stall), 32'(e_stall));
    m_last_stall = e_stall;
    model_edge();
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic cyc(input logic v, input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                     input logic [4:0] d, input logic st, input logic fl);
    id_valid = v; opcode = op; rs = s; rt = t; rd = d; stall_in = st; flush = fl;
    step();
  endtask

  initial begin
    int busy_cnt, float_cnt;
    rst_n = 1'b0; id_valid = 1'b0; opcode = '0; rs = '0; rt = '0; rd = '0;
    stall_in = 1'b0; flush = 1'b0;
    m_reset();

    phase = "reset";
    #12;
    check("reset.if_stall", 32'(if_stall), 32'(0));
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;

    phase = "loaduse";
    cyc(1'b1, 6'h12, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 6'h03, 5'd8, 5'd2, 5'd3, 1'b0, 1'b0);
    check("loaduse.bubble", 32'(ex_valid), 32'(0));
    cyc(1'b1, 6'h03, 5'd8, 5'd2, 5'd3, 1'b0, 1'b0);
    check("loaduse.add_in_ex", 32'({ex_valid, ex_RegDst, ex_dest}), 32'({2'b11, 5'd3}));

    phase = "rt0";
    cyc(1'b1, 6'h12, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 6'h03, 5'd0, 5'd4, 5'd5, 1'b0, 1'b0);
    check("rt0.no_stall_add", 32'({ex_valid, ex_dest}), 32'({1'b1, 5'd5}));

    phase = "fp";
    cyc(1'b1, 6'h11, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    busy_cnt  = int'(fp_busy);
    float_cnt = int'(ex_floatop);
    for (int i = 0; i < FP_LAT; i++) begin
      cyc(1'b1, 6'h09, 5'd3, 5'd7, 5'd0, 1'b0, 1'b0);
      busy_cnt  += int'(fp_busy);
      float_cnt += int'(ex_floatop);
    end
    check("fp.busy_cycles", 32'(busy_cnt), 32'(FP_LAT - 1));
    check("fp.float_cycles", 32'(float_cnt), 32'(1));
    check("fp.addi_after", 32'({ex_valid, ex_ALUSrc, ex_ALUop, if_stall}), 32'({2'b11, 4'h4, 1'b0}));

    phase = "flush";
    cyc(1'b1, 6'h11, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    cyc(1'b1, 6'h0e, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 6'h0e, 5'd1, 5'd9, 5'd0, 1'b0, 1'b1);
    check("flush.idle", 32'({fp_busy, ex_valid, if_stall}), 32'(0));
    cyc(1'b1, 6'h0e, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0);
    check("flush.ori_issues", 32'({ex_valid, ex_ALUop}), 32'({1'b1, 4'h3}));

    phase = "illegal";
    cyc(1'b1, 6'h3f, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    check("illegal.flag", 32'({ex_illegal, ex_valid, obs_ctrl}), 32'({2'b10, 16'h0}));
    cyc(1'b1, 6'h0f, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    cyc(1'b1, 6'h0f, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    check("illegal.frozen", 32'({ex_illegal, ex_valid, obs_ctrl}), 32'({2'b10, 16'h0}));
    cyc(1'b1, 6'h0f, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);

    phase = "async_rst";
    cyc(1'b1, 6'h11, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    cyc(1'b1, 6'h09, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.outputs", 32'({ex_valid, ex_floatop, fp_busy, if_stall, ex_illegal, obs_ctrl}), 32'(0));
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 6'h2b, 5'd2, 5'd6, 5'd0, 1'b0, 1'b0);
    check("async_rst.sw", 32'({ex_valid, ex_MemWrite, ex_ALUSrc, ex_Issigned, ex_RegWrite, ex_ALUop}),
          32'({5'b11110, 4'h4}));

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      if (!m_last_stall) begin
        id_valid = ($urandom_range(0, 7) != 0);
        opcode   = op_pool[$urandom_range(0, 17)];
        rs       = 5'($urandom_range(0, 3));
        rt       = 5'($urandom_range(0, 3));
        rd       = 5'($urandom_range(0, 31));
      end
      stall_in = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
